// File: rtl/exc_ctrl.sv
// Exception/interrupt controller between the MEM stage and CP0: synchronises interrupts,
// forwards in-flight mtc0 writes, prioritises exceptions and sequences commit/flush/hold-off.
module exc_ctrl #(
    parameter logic [31:0] VECTOR  = 32'hBFC0_0380,
    parameter logic [3:0]  HOLDOFF = 4'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  int_i,
    output logic [5:0]  int_sync_o,
    input  logic        mem_valid,
    input  logic        mem_stall,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_addr,
    input  logic        mem_in_delayslot,
    input  logic [8:0]  exc_flags,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] excepttype_o,
    output logic [31:0] epc_addr_o,
    output logic        in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t      state_r;
    logic [3:0]  hold_cnt_r;
    logic [5:0]  int_meta_r;
    logic [5:0]  int_sync_r;
    logic [31:0] excepttype_r;
    logic [31:0] epc_addr_r;
    logic        in_delayslot_r;
    logic [31:0] bad_addr_r;
    logic        flush_r;
    logic [31:0] new_pc_r;
    logic        busy_r;

    logic [31:0] status_s;
    logic [31:0] cause_s;
    logic [31:0] epc_s;
    logic        pending_s;
    logic [4:0]  code_s;
    logic [31:0] bad_addr_s;
    logic        is_eret_s;
    logic        accept_s;

    // Forward the WB-stage mtc0 write so decisions see the value CP0 is about to hold.
    always_comb begin
        status_s = cp0_status;
        cause_s  = cp0_cause;
        epc_s    = cp0_epc;
        if (cp0_we && (cp0_waddr == 5'd12)) begin
            status_s = cp0_wdata;
        end else begin
            status_s = cp0_status;
        end
        if (cp0_we && (cp0_waddr == 5'd13)) begin
            cause_s = {cp0_cause[31:10], cp0_wdata[9:8], cp0_cause[7:0]};
        end else begin
            cause_s = cp0_cause;
        end
        if (cp0_we && (cp0_waddr == 5'd14)) begin
            epc_s = cp0_wdata;
        end else begin
            epc_s = cp0_epc;
        end
    end

    // Interrupts stay masked while the pipeline refills after a redirect.
    always_comb begin
        pending_s = 1'b0;
        if (state_r == ST_HOLD) begin
            pending_s = 1'b0;
        end else begin
            pending_s = (|(status_s[15:8] & cause_s[15:8])) & status_s[0] & ~status_s[1];
        end
    end

    // Priority encoder over the interrupt and the MEM-stage exception flags.
    always_comb begin
        code_s     = 5'h00;
        bad_addr_s = 32'd0;
        is_eret_s  = 1'b0;
        if (pending_s) begin
            code_s = 5'h01;
        end else if (exc_flags[8]) begin
            code_s     = 5'h04;
            bad_addr_s = mem_pc;
        end else if (exc_flags[7]) begin
            code_s = 5'h0a;
        end else if (exc_flags[6]) begin
            code_s = 5'h0c;
        end else if (exc_flags[5]) begin
            code_s = 5'h0d;
        end else if (exc_flags[4]) begin
            code_s = 5'h08;
        end else if (exc_flags[3]) begin
            code_s = 5'h09;
        end else if (exc_flags[2]) begin
            code_s    = 5'h0e;
            is_eret_s = 1'b1;
        end else if (exc_flags[1]) begin
            code_s     = 5'h04;
            bad_addr_s = mem_addr;
        end else if (exc_flags[0]) begin
            code_s     = 5'h05;
            bad_addr_s = mem_addr;
        end else begin
            code_s = 5'h00;
        end
    end

    assign accept_s = mem_valid && !mem_stall && (state_r != ST_COMMIT) && (code_s != 5'h00);

    // Synchroniser, commit sequencing and hold-off countdown; commit outputs pulse for one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            hold_cnt_r     <= 4'd0;
            int_meta_r     <= 6'd0;
            int_sync_r     <= 6'd0;
            excepttype_r   <= 32'd0;
            epc_addr_r     <= 32'd0;
            in_delayslot_r <= 1'b0;
            bad_addr_r     <= 32'd0;
            flush_r        <= 1'b0;
            new_pc_r       <= 32'd0;
            busy_r         <= 1'b0;
        end else begin
            int_meta_r     <= int_i;
            int_sync_r     <= int_meta_r;
            excepttype_r   <= 32'd0;
            epc_addr_r     <= 32'd0;
            in_delayslot_r <= 1'b0;
            bad_addr_r     <= 32'd0;
            flush_r        <= 1'b0;
            new_pc_r       <= 32'd0;
            case (state_r)
                ST_IDLE, ST_HOLD: begin
                    if (accept_s) begin
                        state_r        <= ST_COMMIT;
                        hold_cnt_r     <= 4'd0;
                        busy_r         <= 1'b1;
                        excepttype_r   <= {27'd0, code_s};
                        epc_addr_r     <= mem_pc;
                        in_delayslot_r <= mem_in_delayslot;
                        bad_addr_r     <= bad_addr_s;
                        flush_r        <= 1'b1;
                        new_pc_r       <= is_eret_s ? epc_s : VECTOR;
                    end else if ((state_r == ST_HOLD) && (hold_cnt_r > 4'd1)) begin
                        hold_cnt_r <= hold_cnt_r - 4'd1;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        hold_cnt_r <= 4'd0;
                        busy_r     <= 1'b0;
                    end
                end
                ST_COMMIT: begin
                    state_r    <= ST_HOLD;
                    hold_cnt_r <= HOLDOFF;
                    busy_r     <= 1'b1;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    hold_cnt_r <= 4'd0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign int_sync_o     = int_sync_r;
    assign excepttype_o   = excepttype_r;
    assign epc_addr_o     = epc_addr_r;
    assign in_delayslot_o = in_delayslot_r;
    assign bad_addr_o     = bad_addr_r;
    assign flush_o        = flush_r;
    assign new_pc_o       = new_pc_r;
    assign busy_o         = busy_r;

endmodule
